// File: rtl/t05_find_least_pair.sv
// t05_find_least_pair: scans node frequencies, picks the two least live nodes.
// Define T05_FLV_SUM_WRITE_EN to let this block write the new sum node itself.
module t05_find_least_pair #(
  parameter int CHAR_CNT = 256,
  parameter int SUM_MAX  = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  en,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [8:0]  mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic [8:0]  least1,
  output logic [8:0]  least2,
  output logic [63:0] sum,
  output logic [3:0]  op_fin,
  output logic [6:0]  sum_cnt
);

  localparam logic [8:0] NULLC     = 9'h180;
  localparam logic [8:0] SUM_BASE  = 9'h100;
  localparam logic [8:0] LAST_LEAF = 9'(CHAR_CNT - 1);
  localparam logic [6:0] SUM_LIM   = 7'(SUM_MAX - 1);
  localparam logic [3:0] EN_IDLE   = 4'b0000;
  localparam logic [3:0] EN_RUN    = 4'b0010;
  localparam logic [3:0] FIN_PAIR  = 4'b0010;
  localparam logic [3:0] FIN_TREE  = 4'b0100;
  localparam logic [3:0] FIN_OVF   = 4'b1000;

  typedef enum logic [3:0] {
    S_IDLE, S_RD, S_WAIT, S_CMP, S_RES, S_CLR1, S_CLR2,
`ifdef T05_FLV_SUM_WRITE_EN
    S_WSUM,
`endif
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [8:0]  addr_q, addr_d;
  logic [63:0] rdat_q, rdat_d;
  logic [63:0] m1_q, m1_d, m2_q, m2_d;
  logic        v1_q, v1_d, v2_q, v2_d;
  logic [8:0]  c1_q, c1_d, c2_q, c2_d;
  logic        abort_q, abort_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [8:0]  maddr_q, maddr_d;
  logic [63:0] wdat_q, wdat_d;
  logic [8:0]  l1_q, l1_d, l2_q, l2_d;
  logic [63:0] sum_q, sum_d;
  logic [3:0]  fin_q, fin_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [8:0]  last_addr;
  logic        stop;

  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = wdat_q;
  assign least1    = l1_q;
  assign least2    = l2_q;
  assign sum       = sum_q;
  assign op_fin    = fin_q;
  assign sum_cnt   = cnt_q;

  // Scan end point and whether a write sequence should end in IDLE
  always_comb begin
    last_addr = LAST_LEAF;
    if (cnt_q != 7'd0) last_addr = SUM_BASE + {2'b00, cnt_q} - 9'd1;
    stop = abort_q || (en == EN_IDLE);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rdat_d  = rdat_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    abort_d = abort_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    maddr_d = maddr_q;
    wdat_d  = wdat_q;
    l1_d    = l1_q;
    l2_d    = l2_q;
    sum_d   = sum_q;
    fin_d   = fin_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        addr_d  = 9'd0;
        v1_d    = 1'b0;
        v2_d    = 1'b0;
        abort_d = 1'b0;
        if (en == EN_RUN) state_d = S_RD;
      end
      S_RD: begin
        if (en == EN_IDLE) begin
          state_d = S_IDLE;
        end else begin
          rd_d    = 1'b1;
          maddr_d = addr_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (en == EN_IDLE) begin
          rd_d    = 1'b0;
          state_d = S_IDLE;
        end else if (mem_ack) begin
          rd_d    = 1'b0;
          rdat_d  = mem_rdata;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        if (en == EN_IDLE) begin
          state_d = S_IDLE;
        end else begin
          if (rdat_q != 64'd0) begin
            if (!v1_q || rdat_q < m1_q) begin
              m2_d = m1_q;
              v2_d = v1_q;
              c2_d = c1_q;
              m1_d = rdat_q;
              v1_d = 1'b1;
              c1_d = addr_q;
            end else if (!v2_q || rdat_q < m2_q) begin
              m2_d = rdat_q;
              v2_d = 1'b1;
              c2_d = addr_q;
            end
          end
          if (addr_q == last_addr) begin
            state_d = S_RES;
          end else begin
            addr_d  = (addr_q == LAST_LEAF) ? SUM_BASE : addr_q + 9'd1;
            state_d = S_RD;
          end
        end
      end
      S_RES: begin
        if (v1_q && v2_q) begin
          l1_d  = c1_q;
          l2_d  = c2_q;
          sum_d = m1_q + m2_q;
          if (cnt_q == SUM_LIM) begin
            fin_d   = FIN_OVF;
            state_d = S_DONE;
          end else begin
            state_d = S_CLR1;
          end
        end else if (v1_q) begin
          l1_d    = c1_q;
          l2_d    = NULLC;
          sum_d   = m1_q;
          fin_d   = FIN_PAIR;
          state_d = S_DONE;
        end else begin
          l1_d    = NULLC;
          l2_d    = NULLC;
          sum_d   = 64'd0;
          fin_d   = FIN_TREE;
          state_d = S_DONE;
        end
      end
      S_CLR1: begin
        if (en == EN_IDLE) abort_d = 1'b1;
        if (!wr_q) begin
          wr_d    = 1'b1;
          maddr_d = l1_q;
          wdat_d  = 64'd0;
        end else if (mem_ack) begin
          wr_d    = 1'b0;
          state_d = S_CLR2;
        end
      end
      S_CLR2: begin
        if (en == EN_IDLE) abort_d = 1'b1;
        if (!wr_q) begin
          wr_d    = 1'b1;
          maddr_d = l2_q;
          wdat_d  = 64'd0;
        end else if (mem_ack) begin
          wr_d = 1'b0;
`ifdef T05_FLV_SUM_WRITE_EN
          state_d = S_WSUM;
`else
          cnt_d = cnt_q + 7'd1;
          if (stop) begin
            state_d = S_IDLE;
          end else begin
            fin_d   = FIN_PAIR;
            state_d = S_DONE;
          end
`endif
        end
      end
`ifdef T05_FLV_SUM_WRITE_EN
      S_WSUM: begin
        if (en == EN_IDLE) abort_d = 1'b1;
        if (!wr_q) begin
          wr_d    = 1'b1;
          maddr_d = SUM_BASE + {2'b00, cnt_q};
          wdat_d  = sum_q;
        end else if (mem_ack) begin
          wr_d  = 1'b0;
          cnt_d = cnt_q + 7'd1;
          if (stop) begin
            state_d = S_IDLE;
          end else begin
            fin_d   = FIN_PAIR;
            state_d = S_DONE;
          end
        end
      end
`endif
      S_DONE: begin
        if (en == EN_IDLE) begin
          fin_d   = 4'b0000;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 9'd0;
      rdat_q  <= 64'd0;
      m1_q    <= 64'd0;
      m2_q    <= 64'd0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      c1_q    <= NULLC;
      c2_q    <= NULLC;
      abort_q <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      maddr_q <= 9'd0;
      wdat_q  <= 64'd0;
      l1_q    <= NULLC;
      l2_q    <= NULLC;
      sum_q   <= 64'd0;
      fin_q   <= 4'b0000;
      cnt_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rdat_q  <= rdat_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      abort_q <= abort_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      maddr_q <= maddr_d;
      wdat_q  <= wdat_d;
      l1_q    <= l1_d;
      l2_q    <= l2_d;
      sum_q   <= sum_d;
      fin_q   <= fin_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_t05_find_least_pair.sv
// tb_t05_find_least_pair: random-latency memory plus a sort-based
// reference that predicts the two least live nodes of each run.
module tb_t05_find_least_pair;

  localparam int CHAR_CNT   = 128;
  localparam int SUM_MAX    = 16;
  localparam int RUN_BUDGET = 6000;
  localparam logic [8:0] NULLC = 9'h180;
`ifdef T05_FLV_SUM_WRITE_EN
  localparam int NWR = 3;
`else
  localparam int NWR = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  en = 4'b0000;
  logic        mem_rd, mem_wr;
  logic [8:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = 64'd0;
  logic        mem_ack = 1'b0;
  logic [8:0]  least1, least2;
  logic [63:0] sum;
  logic [3:0]  op_fin;
  logic [6:0]  sum_cnt;

  logic [63:0] mem [0:511];
  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int maxlat = 8;
  int m_scnt = 0;
  logic [8:0]  e_l1, e_l2;
  logic [63:0] e_sum;
  logic [3:0]  e_fin;
  bit          e_pair;

  t05_find_least_pair #(.CHAR_CNT(CHAR_CNT), .SUM_MAX(SUM_MAX)) dut (
    .clk(clk), .rst(rst), .en(en),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .least1(least1), .least2(least2), .sum(sum),
    .op_fin(op_fin), .sum_cnt(sum_cnt)
  );

  always #5 clk = ~clk;

  // Memory responder: random ack latency, request stability checks
  bit          pend = 1'b0;
  int          lat_left = 0;
  logic [8:0]  req_addr;
  logic [63:0] req_wd;
  logic        req_wr;
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
      mem_ack = 1'b0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_rd || mem_wr) begin
      checks++;
      if (mem_rd && mem_wr) begin
        errors++;
        $display("FAIL rd_wr_excl: rd=%b wr=%b, want never both", mem_rd, mem_wr);
      end
      if (!pend) begin
        pend = 1'b1;
        lat_left = int'($urandom_range(maxlat, 1));
        req_addr = mem_addr;
        req_wd = mem_wdata;
        req_wr = mem_wr;
      end else begin
        checks++;
        if (mem_addr !== req_addr || mem_wr !== req_wr ||
            (req_wr && mem_wdata !== req_wd)) begin
          errors++;
          $display("FAIL req_stable: addr=%h wdata=%h want addr=%h wdata=%h",
                   mem_addr, mem_wdata, req_addr, req_wd);
        end
      end
      lat_left--;
      if (lat_left == 0) begin
        pend = 1'b0;
        mem_ack = 1'b1;
        if (mem_wr) begin
          mem[mem_addr] = mem_wdata;
          wr_count++;
        end else begin
          mem_rdata = mem[mem_addr];
        end
      end
    end else begin
      pend = 1'b0;
    end
  end

  task automatic clear_leaves();
    for (int a = 0; a < 256; a++) mem[a] = 64'd0;
  endtask

  task automatic clear_all();
    for (int a = 0; a < 512; a++) mem[a] = 64'd0;
  endtask

  // Reference: sort live nodes by (frequency, address) and take the first two
  task automatic model_pick();
    logic [72:0] q[$];
    for (int a = 0; a < CHAR_CNT; a++)
      if (mem[a] != 64'd0) q.push_back({mem[a], 9'(a)});
    for (int i = 0; i < m_scnt; i++)
      if (mem[256 + i] != 64'd0) q.push_back({mem[256 + i], 9'(256 + i)});
    q.sort();
    e_pair = 1'b0;
    if (q.size() == 0) begin
      e_l1 = NULLC; e_l2 = NULLC; e_sum = 64'd0; e_fin = 4'b0100;
    end else if (q.size() == 1) begin
      e_l1 = q[0][8:0]; e_l2 = NULLC; e_sum = q[0][72:9]; e_fin = 4'b0010;
    end else begin
      e_l1 = q[0][8:0];
      e_l2 = q[1][8:0];
      e_sum = q[0][72:9] + q[1][72:9];
      if (m_scnt == SUM_MAX - 1) begin
        e_fin = 4'b1000;
      end else begin
        e_fin = 4'b0010;
        e_pair = 1'b1;
      end
    end
  endtask

  // Book-keep a completed pair; without the sum-write build the bench
  // plays the agent that fills the new sum slot
  task automatic model_commit();
    if (e_pair) begin
`ifndef T05_FLV_SUM_WRITE_EN
      mem[256 + m_scnt] = e_sum;
`endif
      m_scnt++;
    end
  endtask

  task automatic do_run(output bit to);
    wr_count = 0;
    en = 4'b0010;
    to = 1'b1;
    for (int i = 0; i < RUN_BUDGET; i++) begin
      @(negedge clk);
      if (op_fin !== 4'b0000) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 4'b0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_rd, mem_wr, mem_addr, mem_wdata} !== 75'd0) begin
      errors++;
      $display("FAIL reset_mem: rd=%b wr=%b addr=%h wdata=%h want all 0",
               mem_rd, mem_wr, mem_addr, mem_wdata);
    end
    checks++;
    if ({least1, least2, sum} !== {NULLC, NULLC, 64'd0}) begin
      errors++;
      $display("FAIL reset_out: %h %h %0d want 180 180 0", least1, least2, sum);
    end
    checks++;
    if ({op_fin, sum_cnt} !== 11'd0) begin
      errors++;
      $display("FAIL reset_status: fin=%b cnt=%0d want 0 0", op_fin, sum_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit to;
    clear_all();
    mem[9'h61] = 64'd5;
    mem[9'h62] = 64'd2;
    mem[9'h63] = 64'd9;
    model_pick();
    do_run(to);
    checks++;
    if (to || {least1, least2, sum, op_fin} !== {9'h062, 9'h061, 64'd7, 4'b0010}) begin
      errors++;
      $display("FAIL basic_pair: got %h %h %0d %b to=%b want 062 061 7 0010",
               least1, least2, sum, op_fin, to);
    end
    checks++;
    if (mem[9'h61] !== 64'd0 || mem[9'h62] !== 64'd0 ||
        wr_count != NWR || sum_cnt !== 7'd1) begin
      errors++;
      $display("FAIL basic_mem: m61=%0d m62=%0d wr=%0d cnt=%0d want 0 0 %0d 1",
               mem[9'h61], mem[9'h62], wr_count, sum_cnt, NWR);
    end
`ifdef T05_FLV_SUM_WRITE_EN
    checks++;
    if (mem[256] !== 64'd7) begin
      errors++;
      $display("FAIL basic_wsum: slot256=%0d want 7", mem[256]);
    end
`endif
    model_commit();
    en = 4'b0000;
    @(negedge clk);
    checks++;
    if (op_fin !== 4'b0000) begin
      errors++;
      $display("FAIL basic_fin_clr: fin=%b want 0000", op_fin);
    end
  endtask

  task automatic test_tie();
    bit to;
    clear_leaves();
    mem[9'h78] = 64'd3;
    mem[9'h79] = 64'd3;
    mem[9'h7a] = 64'd3;
    model_pick();
    do_run(to);
    checks++;
    if (to || {least1, least2, sum, op_fin} !== {9'h078, 9'h079, 64'd6, 4'b0010}) begin
      errors++;
      $display("FAIL tie_pair: got %h %h %0d %b want 078 079 6 0010",
               least1, least2, sum, op_fin);
    end
    checks++;
    if (wr_count != NWR || int'(sum_cnt) != m_scnt + 1) begin
      errors++;
      $display("FAIL tie_cnt: wr=%0d cnt=%0d want %0d %0d",
               wr_count, sum_cnt, NWR, m_scnt + 1);
    end
    model_commit();
    en = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit to;
    clear_all();
    mem[9'h71] = 64'd4;
    model_pick();
    do_run(to);
    checks++;
    if (to || {least1, least2, sum, op_fin} !== {9'h071, NULLC, 64'd4, 4'b0010}) begin
      errors++;
      $display("FAIL single_out: got %h %h %0d %b want 071 180 4 0010",
               least1, least2, sum, op_fin);
    end
    checks++;
    if (wr_count != 0 || int'(sum_cnt) != m_scnt || mem[9'h71] !== 64'd4) begin
      errors++;
      $display("FAIL single_nowr: wr=%0d cnt=%0d m71=%0d want 0 %0d 4",
               wr_count, sum_cnt, mem[9'h71], m_scnt);
    end
    model_commit();
    en = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_empty();
    bit to;
    clear_all();
    en = 4'b0001;
    repeat (20) @(negedge clk);
    checks++;
    if (mem_rd !== 1'b0 || op_fin !== 4'b0000) begin
      errors++;
      $display("FAIL hold_idle: rd=%b fin=%b want 0 0000", mem_rd, op_fin);
    end
    model_pick();
    do_run(to);
    checks++;
    if (to || {least1, least2, sum, op_fin} !== {NULLC, NULLC, 64'd0, 4'b0100}) begin
      errors++;
      $display("FAIL empty_out: got %h %h %0d %b want 180 180 0 0100",
               least1, least2, sum, op_fin);
    end
    en = 4'b0000;
    @(negedge clk);
    checks++;
    if (op_fin !== 4'b0000) begin
      errors++;
      $display("FAIL empty_fin_clr: fin=%b want 0000", op_fin);
    end
  endtask

  task automatic test_random(input int n);
    bit to;
    int k;
    for (int r = 0; r < n; r++) begin
      clear_leaves();
      k = int'($urandom_range(8, 2));
      for (int j = 0; j < k; j++)
        mem[$urandom_range(CHAR_CNT - 1, 0)] = 64'($urandom_range(20, 1));
      model_pick();
      do_run(to);
      checks++;
      if (to || {least1, least2, sum, op_fin} !== {e_l1, e_l2, e_sum, e_fin}) begin
        errors++;
        $display("FAIL rand_out[%0d]: got %h %h %0d %b want %h %h %0d %b",
                 r, least1, least2, sum, op_fin, e_l1, e_l2, e_sum, e_fin);
      end
      checks++;
      if (wr_count != (e_pair ? NWR : 0) ||
          int'(sum_cnt) != m_scnt + (e_pair ? 1 : 0) ||
          (e_pair && (mem[e_l1] !== 64'd0 || mem[e_l2] !== 64'd0))) begin
        errors++;
        $display("FAIL rand_mem[%0d]: wr=%0d cnt=%0d want wr=%0d cnt=%0d",
                 r, wr_count, sum_cnt, e_pair ? NWR : 0, m_scnt + (e_pair ? 1 : 0));
      end
      model_commit();
      en = 4'b0000;
      @(negedge clk);
    end
  endtask

  task automatic test_abort_scan();
    bit seen;
    clear_leaves();
    mem[3] = 64'd4;
    mem[40] = 64'd6;
    mem[90] = 64'd1;
    wr_count = 0;
    seen = 1'b0;
    en = 4'b0010;
    for (int i = 0; i < RUN_BUDGET && !seen; i++) begin
      @(negedge clk);
      if (mem_rd && mem_addr == 9'd20) seen = 1'b1;
    end
    en = 4'b0000;
    @(negedge clk);
    checks++;
    if (!seen || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
      errors++;
      $display("FAIL abort_scan_req: seen=%b rd=%b wr=%b want 1 0 0",
               seen, mem_rd, mem_wr);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (wr_count != 0 || int'(sum_cnt) != m_scnt || op_fin !== 4'b0000 ||
        mem[90] !== 64'd1) begin
      errors++;
      $display("FAIL abort_scan_state: wr=%0d cnt=%0d fin=%b want 0 %0d 0000",
               wr_count, sum_cnt, op_fin, m_scnt);
    end
  endtask

  task automatic test_abort_clr();
    bit seen;
    bit finbad;
    model_pick();
    wr_count = 0;
    seen = 1'b0;
    finbad = 1'b0;
    en = 4'b0010;
    for (int i = 0; i < RUN_BUDGET && !seen; i++) begin
      @(negedge clk);
      if (mem_wr) seen = 1'b1;
    end
    en = 4'b0000;
    for (int i = 0; i < 200 && wr_count < NWR; i++) begin
      @(negedge clk);
      if (op_fin !== 4'b0000) finbad = 1'b1;
    end
    repeat (10) begin
      @(negedge clk);
      if (op_fin !== 4'b0000 || mem_rd || mem_wr) finbad = 1'b1;
    end
    checks++;
    if (!seen || wr_count != NWR || int'(sum_cnt) != m_scnt + 1) begin
      errors++;
      $display("FAIL abort_clr_wr: seen=%b wr=%0d cnt=%0d want 1 %0d %0d",
               seen, wr_count, sum_cnt, NWR, m_scnt + 1);
    end
    checks++;
    if (mem[e_l1] !== 64'd0 || mem[e_l2] !== 64'd0) begin
      errors++;
      $display("FAIL abort_clr_mem: m[%h]=%0d m[%h]=%0d want 0 0",
               e_l1, mem[e_l1], e_l2, mem[e_l2]);
    end
`ifdef T05_FLV_SUM_WRITE_EN
    checks++;
    if (mem[256 + m_scnt] !== e_sum) begin
      errors++;
      $display("FAIL abort_clr_wsum: got %0d want %0d", mem[256 + m_scnt], e_sum);
    end
`endif
    checks++;
    if (finbad) begin
      errors++;
      $display("FAIL abort_clr_idle: fin/req seen active=%b want 0", finbad);
    end
    model_commit();
  endtask

  task automatic test_overflow();
    bit to;
    clear_leaves();
    for (int j = 0; j < 20; j++) mem[j * 5 + 1] = 64'($urandom_range(50, 1));
    maxlat = 3;
    for (int r = 0; r < SUM_MAX && m_scnt < SUM_MAX - 1; r++) begin
      model_pick();
      do_run(to);
      checks++;
      if (to || {least1, least2, sum, op_fin} !== {e_l1, e_l2, e_sum, e_fin} ||
          wr_count != NWR) begin
        errors++;
        $display("FAIL fill_run[%0d]: got %h %h %0d %b wr=%0d want %h %h %0d %b wr=%0d",
                 r, least1, least2, sum, op_fin, wr_count,
                 e_l1, e_l2, e_sum, e_fin, NWR);
      end
      model_commit();
      en = 4'b0000;
      @(negedge clk);
    end
    model_pick();
    do_run(to);
    checks++;
    if (to || {least1, least2, sum, op_fin} !== {e_l1, e_l2, e_sum, e_fin}) begin
      errors++;
      $display("FAIL ovf_out: got %h %h %0d %b want %h %h %0d %b",
               least1, least2, sum, op_fin, e_l1, e_l2, e_sum, e_fin);
    end
    checks++;
    if (op_fin !== 4'b1000 || wr_count != 0 || int'(sum_cnt) != SUM_MAX - 1) begin
      errors++;
      $display("FAIL ovf_status: fin=%b wr=%0d cnt=%0d want 1000 0 %0d",
               op_fin, wr_count, sum_cnt, SUM_MAX - 1);
    end
    en = 4'b0000;
    @(negedge clk);
    maxlat = 8;
  endtask

  task automatic test_rst_wait();
    bit seen;
    clear_leaves();
    mem[10] = 64'd3;
    mem[20] = 64'd5;
    seen = 1'b0;
    en = 4'b0010;
    for (int i = 0; i < RUN_BUDGET && !seen; i++) begin
      @(negedge clk);
      if (mem_rd && mem_addr == 9'd8) seen = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (!seen || {mem_rd, mem_wr, mem_addr, mem_wdata} !== 75'd0 ||
        {least1, least2, sum, op_fin, sum_cnt} !== {NULLC, NULLC, 64'd0, 11'd0}) begin
      errors++;
      $display("FAIL rst_wait: seen=%b rd=%b addr=%h l1=%h l2=%h sum=%0d fin=%b cnt=%0d want reset values",
               seen, mem_rd, mem_addr, least1, least2, sum, op_fin, sum_cnt);
    end
    rst = 1'b0;
    en = 4'b0000;
    m_scnt = 0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_single();
    test_empty();
    test_random(4);
    test_abort_scan();
    test_abort_clr();
    test_overflow();
    test_rst_wait();
    test_random(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
